// File: rtl/param_read_pkg.sv
// -----------------------------------------------------------------------------
// param_read_pkg
// Shared types for the parameter read sequencer: FSM state encoding, the
// per-word tag that travels alongside each RAM read, and the read-credit rule.
// -----------------------------------------------------------------------------
package param_read_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_BIAS  = 3'd1,
    READ_DATA  = 3'd2,
    READ_STALL = 3'd3,
    READ_FINAL = 3'd4
  } read_state_t;

  typedef struct packed {
    logic is_bias;
    logic last_kernel;
    logic last;
  } read_tag_t;

  localparam int TAG_W = $bits(read_tag_t);

  // A new read may issue only if, after this cycle's pop, the words already
  // buffered plus the one still in flight leave a free FIFO slot.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] used;
    logic [2:0] limit;
    used  = {1'b0, count} + {2'b0, inflight};
    limit = 3'd2 + {2'b0, pop};
    return (used < limit);
  endfunction

endpackage

// File: rtl/param_read_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo2
// Two-entry FIFO used to decouple the RAM read pipeline from the consumer.
// Push and pop may occur in the same cycle, including when full: the popped
// slot is the one being overwritten, and the head is read before the edge.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (flushes the FIFO)
//   push        - write push_data at the tail
//   push_data   - entry to write
//   pop         - remove the head entry (ignored when empty)
//   count       - number of entries held (0..2)
//   head        - oldest entry (meaningful when count != 0)
// -----------------------------------------------------------------------------
module stream_fifo2 #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/param_read_sequencer.sv
// -----------------------------------------------------------------------------
// param_read_sequencer
// Walks NUM_FILTERS records of (1 bias + KERNEL_LEN weights) stored
// contiguously from base_addr in a single-port synchronous RAM and streams
// the words to the compute datapath over valid/ready, tagged with bias /
// last-kernel / last-of-run flags.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start, base_addr - one-cycle run request and first bias address
//   busy, done       - run in progress, one-cycle completion pulse
//   ram_addr, ram_rden, ram_q - RAM read port (data one cycle after rden)
//   out_data, out_valid, out_ready - output stream
//   out_is_bias, out_last_kernel, out_last - per-word flags
// -----------------------------------------------------------------------------
module param_read_sequencer
  import param_read_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int KERNEL_LEN  = 9,
  parameter int NUM_FILTERS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_bias,
  output logic              out_last_kernel,
  output logic              out_last
);

  localparam int WI_W   = $clog2(KERNEL_LEN + 1);
  localparam int FI_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int FIFO_W = DATA_W + TAG_W;

  read_state_t       state;
  read_state_t       saved_state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [WI_W-1:0]   word_idx;     // weights already issued for this filter
  logic [FI_W-1:0]   filter_idx;
  logic              busy_q;
  logic              done_q;

  logic              issue;
  read_tag_t         issue_tag;
  logic              last_weight;
  logic              last_filter;
  logic              can_issue;

  logic              vld_p1;
  read_tag_t         tag_p1;

  logic              pop;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  read_tag_t         head_tag;

  assign last_weight = (word_idx == WI_W'(KERNEL_LEN - 1));
  assign last_filter = (filter_idx == FI_W'(NUM_FILTERS - 1));
  assign pop         = out_valid && out_ready;
  assign can_issue   = credit_ok(fifo_count, vld_p1, pop);

  always_comb begin
    issue     = 1'b0;
    issue_tag = '0;
    case (state)
      READ_BIAS: begin
        if (can_issue) begin
          issue             = 1'b1;
          issue_tag.is_bias = 1'b1;
        end
      end
      READ_DATA: begin
        if (can_issue) begin
          issue                 = 1'b1;
          issue_tag.last_kernel = last_weight;
          issue_tag.last        = last_weight && last_filter;
        end
      end
      default: ;
    endcase
  end

  // Stage p0: FSM, address counter and read issue
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      saved_state <= IDLE;
      addr_cnt    <= '0;
      word_idx    <= '0;
      filter_idx  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_p1 <= issue;
      if (issue) addr_cnt <= addr_cnt + 1'b1;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old run.
          if (start && !done_q) begin
            addr_cnt   <= base_addr;
            word_idx   <= '0;
            filter_idx <= '0;
            busy_q     <= 1'b1;
            state      <= READ_BIAS;
          end
        end
        READ_BIAS: begin
          if (issue) begin
            state <= READ_DATA;
          end else begin
            saved_state <= READ_BIAS;
            state       <= READ_STALL;
          end
        end
        READ_DATA: begin
          if (issue) begin
            if (last_weight) begin
              word_idx <= '0;
              if (last_filter) begin
                state <= READ_FINAL;
              end else begin
                filter_idx <= filter_idx + 1'b1;
                state      <= READ_BIAS;
              end
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end else begin
            saved_state <= READ_DATA;
            state       <= READ_STALL;
          end
        end
        READ_STALL: begin
          if (can_issue) state <= saved_state;
        end
        READ_FINAL: begin
          // The word tagged last is the final one pushed, so its handshake
          // means the pipeline and FIFO are empty.
          if (pop && head_tag.last) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_p1 <= issue_tag;
  end

  // Stage p1: RAM data lands and is pushed with its tag
  stream_fifo2 #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data ({ram_q, tag_p1}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Stage p2: FIFO head drives the stream
  assign head_tag  = read_tag_t'(fifo_head[TAG_W-1:0]);
  assign out_valid = (fifo_count != 2'd0);

  // Outputs read as zero whenever nothing is valid, including after reset.
  assign out_data        = out_valid ? fifo_head[FIFO_W-1:TAG_W] : '0;
  assign out_is_bias     = out_valid && head_tag.is_bias;
  assign out_last_kernel = out_valid && head_tag.last_kernel;
  assign out_last        = out_valid && head_tag.last;

  assign ram_rden = issue;
  assign ram_addr = addr_cnt;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_read_sequencer.sv
module tb_param_read_sequencer;

  localparam int K  = 2;
  localparam int NF = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic [15:0] ram_addr;
  logic        ram_rden;
  logic [7:0]  ram_q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_bias;
  logic        out_last_kernel;
  logic        out_last;

  param_read_sequencer #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .KERNEL_LEN  (K),
    .NUM_FILTERS (NF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .busy            (busy),
    .done            (done),
    .ram_addr        (ram_addr),
    .ram_rden        (ram_rden),
    .ram_q           (ram_q),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_is_bias     (out_is_bias),
    .out_last_kernel (out_last_kernel),
    .out_last        (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: address 0x0010+i holds 0xA0+i, and so on around the space.
  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return a[7:0] + 8'h90;
  endfunction

  always @(posedge clk) begin
    if (ram_rden) ram_q <= ram_val(ram_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       b;
    logic       lk;
    logic       l;
  } word_t;

  word_t       word_q[$];
  logic [15:0] addr_q[$];
  word_t       log_w[$];
  logic [15:0] log_a[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          outstanding = 0;
  int          cyc = 0;
  int          first_rd_cyc = -1;
  int          first_v_cyc = -1;
  int          done_cyc = -1;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  word_t       prev_w;

  task automatic enqueue_run(input logic [15:0] base);
    logic [15:0] a;
    word_t       w;
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k <= K; k++) begin
        a      = base + 16'(f * (K + 1) + k);
        w.data = ram_val(a);
        w.b    = (k == 0);
        w.lk   = (k == K);
        w.l    = (k == K) && (f == NF - 1);
        addr_q.push_back(a);
        word_q.push_back(w);
      end
    end
  endtask

  always @(negedge clk) begin
    word_t cur;
    word_t exp_w;
    logic  hs_last;
    cyc++;
    cur = {out_data, out_is_bias, out_last_kernel, out_last};
    if (reset) begin
      word_q.delete();
      addr_q.delete();
      m_busy      = 1'b0;
      m_done      = 1'b0;
      outstanding = 0;
      prev_v      = 1'b0;
      prev_r      = 1'b0;
    end else begin
      hs_last = 1'b0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ram_rden) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        outstanding++;
        if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          log_a.push_back(ram_addr);
          chk("ram_addr", ram_addr, addr_q.pop_front());
        end
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", cur, prev_w);
      end
      if (out_valid) begin
        if (first_v_cyc < 0) first_v_cyc = cyc;
        if (word_q.size() == 0) chk("valid_without_word", 1, 0);
        else if (out_ready) begin
          exp_w = word_q.pop_front();
          chk("word", cur, exp_w);
          log_w.push_back(cur);
          outstanding--;
          hs_last = exp_w.l;
        end
      end
      chk("outstanding_le_2", (outstanding <= 2), 1);
      prev_v = out_valid;
      prev_r = out_ready;
      prev_w = cur;
      // next-cycle expectations
      m_done = hs_last;
      if (hs_last) m_busy = 1'b0;
      if (start && !m_busy && !done) begin
        enqueue_run(base_addr);
        m_busy       = 1'b1;
        cyc          = 0;
        first_rd_cyc = -1;
        first_v_cyc  = -1;
        done_cyc     = -1;
        rd_cnt       = 0;
        done_cnt     = 0;
        log_w.delete();
        log_a.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always, 1: ready low in cycles 4..9, 2: random ready and
  // spurious starts, 3: second start with base 0x0100 mid-run
  task automatic run(input logic [15:0] base, input int mode);
    bit seen;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      base_addr = (c == 0) ? base : 16'h0100;
      start     = (c == 0) || (mode == 3 && c == 5) ||
                  (mode == 2 && $urandom_range(0, 15) == 0);
      case (mode)
        1:       out_ready = !(c >= 4 && c <= 9);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (done) seen = 1;
      tick();
    end
    start = 1'b0;
    chk("run_completes", seen, 1);
    tick();
    tick();
  endtask

  task automatic check_full_sequence(input string tag);
    chk({tag, "_n_words"}, log_w.size(), 6);
    if (log_w.size() == 6) begin
      chk({tag, "_w0"}, log_w[0], {8'hA0, 3'b100});
      chk({tag, "_w1"}, log_w[1], {8'hA1, 3'b000});
      chk({tag, "_w2"}, log_w[2], {8'hA2, 3'b010});
      chk({tag, "_w3"}, log_w[3], {8'hA3, 3'b100});
      chk({tag, "_w4"}, log_w[4], {8'hA4, 3'b000});
      chk({tag, "_w5"}, log_w[5], {8'hA5, 3'b011});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rden", ram_rden, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", {out_data, out_is_bias, out_last_kernel, out_last}, 0);
    tick();

    // full throughput
    run(16'h0010, 0);
    chk("lat_first_rden", first_rd_cyc, 1);
    chk("lat_first_valid", first_v_cyc, 3);
    chk("lat_done", done_cyc, 9);
    chk("full_addr0", (log_a.size() > 0) ? log_a[0] : 16'hxxxx, 16'h0010);
    chk("full_addr5", (log_a.size() > 5) ? log_a[5] : 16'hxxxx, 16'h0015);
    check_full_sequence("full");

    // backpressure
    run(16'h0010, 1);
    check_full_sequence("bp");

    // address wrap
    run(16'hFFFE, 0);
    chk("wrap_a0", (log_a.size() > 2) ? log_a[0] : 16'hxxxx, 16'hFFFE);
    chk("wrap_a1", (log_a.size() > 2) ? log_a[1] : 16'hxxxx, 16'hFFFF);
    chk("wrap_a2", (log_a.size() > 2) ? log_a[2] : 16'hxxxx, 16'h0000);
    chk("wrap_w2", (log_w.size() > 2) ? log_w[2] : 11'hxxx, {8'h90, 3'b010});

    // ignored start mid-run
    run(16'h0010, 3);
    chk("ign_done_count", done_cnt, 1);
    check_full_sequence("ign");

    // reset mid-run while issuing weights of the second filter
    base_addr = 16'h0010;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rden", ram_rden, 0);
    chk("mrst_done", done, 0);
    tick();
    run(16'h0010, 0);
    check_full_sequence("after_rst");

    // consumer never ready
    base_addr = 16'h0010;
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    chk("stall_rd_cnt", rd_cnt, 2);
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 8'hA0);
    chk("stall_busy", busy, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      run(16'($urandom), 2);
      chk("rand_n_words", log_w.size(), NF * (K + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
